// File: rtl/d8_stack.sv
// Byte LIFO on a 64-entry sync RAM with a full-descending byte pointer stepping by 4.
// Push: busy 1 cycle after request; pop: dout/valid 2 cycles after request. Requests while busy are dropped.
module d8_stack #(
    parameter int DW    = 8,
    parameter int DEPTH = 64
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          busy,
    output logic [7:0]    sp,
    output logic          empty,
    output logic          full,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, POP_DATA} state_t;

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    state_t        state_q;
    logic [7:0]    sp_q;
    logic [7:0]    sp_dec;
    logic [6:0]    count_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] rd_q;
    logic          valid_q;
    logic          err_q;

    logic [DW-1:0] mem [DEPTH];

    assign sp_dec = sp_q - 8'd4;

    // No reset on the array: a push write racing a reset is allowed to land.
    always_ff @(posedge sys_clk) begin
        if (state_q == PUSH_WR) begin
            mem[sp_dec[7:2]] <= din_q;
        end
        rd_q <= mem[sp_q[7:2]];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            sp_q    <= 8'h00;
            count_q <= 7'd0;
            din_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (push && pop) begin
                        err_q <= 1'b1;
                    end else if (push) begin
                        if (full) begin
                            err_q <= 1'b1;
                        end else begin
                            din_q   <= din;
                            state_q <= PUSH_WR;
                        end
                    end else if (pop) begin
                        if (empty) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= POP_RD;
                        end
                    end
                end
                PUSH_WR: begin
                    sp_q    <= sp_dec;
                    count_q <= count_q + 7'd1;
                    state_q <= IDLE;
                end
                // rd_q captures mem[sp] on this edge; sp is stable through POP_RD.
                POP_RD: begin
                    state_q <= POP_DATA;
                end
                POP_DATA: begin
                    dout_q  <= rd_q;
                    valid_q <= 1'b1;
                    sp_q    <= sp_q + 8'd4;
                    count_q <= count_q - 7'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // sp alone is ambiguous (00 both empty and after DEPTH pushes), so flags come from count.
    assign empty = (count_q == 7'd0);
    assign full  = (count_q == DEPTH_C);
    assign busy  = (state_q != IDLE);
    assign sp    = sp_q;
    assign dout  = dout_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
